// File: rtl/weight_fifo_pkg.sv
// tpu_package: shared TPU array size, weight row type and FIFO stall timeout
package tpu_package;
   localparam int MUL_SIZE      = 8;
   localparam int WEIGHT_W      = 8;
   localparam int WFIFO_TIMEOUT = 1024;
   typedef logic [MUL_SIZE-1:0][WEIGHT_W-1:0] weight_row_t;
endpackage

// File: rtl/weight_fifo_ram.sv
// weight_fifo_ram: simple dual-port row store, one write port and one registered read port
module weight_fifo_ram
   import tpu_package::*;
#(
   parameter int DEPTH = 32,
   parameter int W     = $bits(weight_row_t),
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [W-1:0]  wr_data_i,
   input  logic          rd_en_i,
   input  logic [AW-1:0] rd_addr_i,
   output logic [W-1:0]  rd_data_o
);
   logic [W-1:0] r_mem [DEPTH];
   // store accepted rows; the array itself has no reset
   always_ff @(posedge clk_i)
      if (wr_en_i) r_mem[wr_addr_i] <= wr_data_i;
   // registered read; holds the last popped row between pops
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) rd_data_o <= '0;
      else if (rd_en_i) rd_data_o <= r_mem[rd_addr_i];
endmodule

// File: rtl/weight_fifo.sv
// weight_fifo: tile-aware weight row FIFO feeding the systolic array; optional err_o with WEIGHT_FIFO_ERR_EN
module weight_fifo
   import tpu_package::*;
#(
   parameter int MUL_SIZE    = tpu_package::MUL_SIZE,
   parameter int DEPTH_TILES = 4,
   localparam int TW         = $clog2(DEPTH_TILES) + 1,
   localparam int W          = MUL_SIZE * WEIGHT_W
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          wr_valid_i,
   input  logic [W-1:0]  wr_data_i,
   output logic          wr_ready_o,
   input  logic          load_weights_i,
   output logic [W-1:0]  rd_data_o,
   output logic          rd_valid_o,
   output logic          rd_last_o,
   output logic          weight_fifo_valid_output,
   output logic [TW-1:0] tiles_avail_o
`ifdef WEIGHT_FIFO_ERR_EN
   ,output logic         err_o
`endif
);
   localparam int DEPTH = DEPTH_TILES * MUL_SIZE;
   localparam int AW    = $clog2(DEPTH);
   localparam int RW    = MUL_SIZE > 1 ? $clog2(MUL_SIZE) : 1;
   localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
   localparam logic [RW-1:0] ROW_LAST = RW'(MUL_SIZE - 1);

   logic [AW:0]   r_wr_ptr, r_rd_ptr, r_count;
   logic [RW-1:0] r_wr_row, r_rd_row;
   logic [TW-1:0] r_tiles;
   logic          r_rd_valid, r_rd_last;
   logic          w_wr_ready, w_valid, w_wr, w_rd, w_wr_last, w_rd_last;

   assign w_wr_ready = r_count != FULL;
   assign w_valid    = r_tiles != '0;
   assign w_wr       = wr_valid_i && w_wr_ready;
   assign w_rd       = load_weights_i && w_valid;
   assign w_wr_last  = w_wr && r_wr_row == ROW_LAST;
   assign w_rd_last  = w_rd && r_rd_row == ROW_LAST;

   assign wr_ready_o               = w_wr_ready;
   assign weight_fifo_valid_output = w_valid;
   assign tiles_avail_o            = r_tiles;
   assign rd_valid_o               = r_rd_valid;
   assign rd_last_o                = r_rd_last;

   weight_fifo_ram #(.DEPTH(DEPTH), .W(W)) u_ram (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_en_i   (w_wr),
      .wr_addr_i (r_wr_ptr[AW-1:0]),
      .wr_data_i (wr_data_i),
      .rd_en_i   (w_rd),
      .rd_addr_i (r_rd_ptr[AW-1:0]),
      .rd_data_o (rd_data_o)
   );

   // pointers, occupancy, in-tile row positions and complete-tile count
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_wr_row   <= '0;
         r_rd_row   <= '0;
         r_tiles    <= '0;
         r_rd_valid <= 1'b0;
         r_rd_last  <= 1'b0;
      end else begin
         r_wr_ptr   <= r_wr_ptr + (AW+1)'(w_wr);
         r_rd_ptr   <= r_rd_ptr + (AW+1)'(w_rd);
         r_count    <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
         r_wr_row   <= w_wr ? (w_wr_last ? '0 : r_wr_row + 1'b1) : r_wr_row;
         r_rd_row   <= w_rd ? (w_rd_last ? '0 : r_rd_row + 1'b1) : r_rd_row;
         r_tiles    <= r_tiles + TW'(w_wr_last) - TW'(w_rd_last);
         r_rd_valid <= w_rd;
         r_rd_last  <= w_rd_last;
      end
   end

`ifdef WEIGHT_FIFO_ERR_EN
   localparam int SW = $clog2(WFIFO_TIMEOUT) + 1;
   localparam logic [SW-1:0] STALL_MAX = SW'(WFIFO_TIMEOUT);
   logic [SW-1:0] r_stall;
   logic          r_err;
   logic          w_stalled;
   assign w_stalled = wr_valid_i && !w_wr_ready;
   assign err_o     = r_err;
   // sticky error on an ignored pop or a write stalled past the timeout
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_stall <= '0;
         r_err   <= 1'b0;
      end else begin
         r_stall <= w_stalled ? (r_stall == STALL_MAX ? r_stall : r_stall + 1'b1) : '0;
         if ((load_weights_i && !w_valid) || (w_stalled && r_stall == STALL_MAX)) r_err <= 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_weight_fifo.sv
// tb_weight_fifo: table vectors, hand sequences and random traffic against a queue-based model
module tb_weight_fifo;
   localparam int M  = 8;
   localparam int DT = 4;
   localparam int D  = M * DT;

   typedef struct {
      logic        wv;
      logic [63:0] d;
      logic        lw;
      logic        rv;
      logic        last;
      logic        valid;
      logic        ready;
      logic [2:0]  tiles;
      logic [63:0] data;
   } vec_t;

   logic          clk_i = 1'b0, rst_i = 1'b0, wr_valid_i = 1'b0, load_weights_i = 1'b0;
   logic [M*8-1:0] wr_data_i = '0;
   logic [M*8-1:0] rd_data_o;
   logic          wr_ready_o, rd_valid_o, rd_last_o, weight_fifo_valid_output;
   logic [2:0]    tiles_avail_o;
`ifdef WEIGHT_FIFO_ERR_EN
   logic          err_o;
`endif

   int            n_vec = 0, n_bad = 0;
   logic [63:0]   mq [$];
   int            wr_cnt = 0, rd_cnt = 0;
   logic [63:0]   m_data = '0;
   logic          m_rv = 1'b0, m_last = 1'b0;
   vec_t          tv [$];

   always #5 clk_i = ~clk_i;

   weight_fifo #(.MUL_SIZE(M), .DEPTH_TILES(DT)) dut (
      .clk_i                    (clk_i),
      .rst_i                    (rst_i),
      .wr_valid_i               (wr_valid_i),
      .wr_data_i                (wr_data_i),
      .wr_ready_o               (wr_ready_o),
      .load_weights_i           (load_weights_i),
      .rd_data_o                (rd_data_o),
      .rd_valid_o               (rd_valid_o),
      .rd_last_o                (rd_last_o),
      .weight_fifo_valid_output (weight_fifo_valid_output),
      .tiles_avail_o            (tiles_avail_o)
`ifdef WEIGHT_FIFO_ERR_EN
      ,.err_o                   (err_o)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] row(input int k);
      return {8{8'(k)}};
   endfunction

   function automatic vec_t mk(input logic wv, input logic [63:0] d, input logic lw, input logic rv,
                               input logic last, input logic valid, input logic ready,
                               input logic [2:0] tiles, input logic [63:0] data);
      vec_t v;
      v.wv = wv; v.d = d; v.lw = lw; v.rv = rv; v.last = last;
      v.valid = valid; v.ready = ready; v.tiles = tiles; v.data = data;
      return v;
   endfunction

   task automatic model_reset();
      mq.delete();
      wr_cnt = 0;
      rd_cnt = 0;
      m_data = '0;
      m_rv   = 1'b0;
      m_last = 1'b0;
   endtask

   task automatic do_reset();
      wr_valid_i = 1'b0;
      load_weights_i = 1'b0;
      wr_data_i = '0;
      rst_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b1;
      model_reset();
   endtask

   // one clock: drive, let the edge pass, advance the model, compare
   task automatic step(input logic wv, input logic [63:0] d, input logic lw);
      bit ready, valid, wr, rd;
      int tiles;
      wr_valid_i = wv;
      wr_data_i = d;
      load_weights_i = lw;
      ready = mq.size() != D;
      valid = (wr_cnt / M - rd_cnt / M) > 0;
      wr = wv && ready;
      rd = lw && valid;
      @(posedge clk_i);
      #1;
      m_rv = rd;
      m_last = 1'b0;
      if (rd) begin
         m_data = mq.pop_front();
         rd_cnt++;
         m_last = (rd_cnt % M) == 0;
      end
      if (wr) begin
         mq.push_back(d);
         wr_cnt++;
      end
      tiles = wr_cnt / M - rd_cnt / M;
      chk("rd_valid", 64'(rd_valid_o), 64'(m_rv));
      chk("rd_last", 64'(rd_last_o), 64'(m_last));
      chk("rd_data", rd_data_o, m_data);
      chk("wr_ready", 64'(wr_ready_o), 64'(mq.size() != D));
      chk("tiles_avail", 64'(tiles_avail_o), 64'(tiles));
      chk("wf_valid", 64'(weight_fifo_valid_output), 64'(tiles > 0));
   endtask

   initial begin
      for (int k = 1; k <= 8; k++)
         tv.push_back(mk(1'b1, row(k), 1'b0, 1'b0, 1'b0, k == 8, 1'b1, (k == 8) ? 3'd1 : 3'd0, 64'd0));
      for (int k = 1; k <= 8; k++)
         tv.push_back(mk(1'b0, 64'd0, 1'b1, 1'b1, k == 8, k != 8, 1'b1, (k == 8) ? 3'd0 : 3'd1, row(k)));
      tv.push_back(mk(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, row(8)));
      for (int k = 9; k <= 15; k++)
         tv.push_back(mk(1'b1, row(k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, row(8)));
      for (int k = 0; k < 3; k++)
         tv.push_back(mk(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, row(8)));

      do_reset();
      chk("rst_ready", 64'(wr_ready_o), 64'd1);
      chk("rst_valid", 64'(weight_fifo_valid_output), 64'd0);
      chk("rst_data", rd_data_o, 64'd0);

      foreach (tv[i]) begin
         step(tv[i].wv, tv[i].d, tv[i].lw);
         chk("tv_rd_valid", 64'(rd_valid_o), 64'(tv[i].rv));
         chk("tv_rd_last", 64'(rd_last_o), 64'(tv[i].last));
         chk("tv_wf_valid", 64'(weight_fifo_valid_output), 64'(tv[i].valid));
         chk("tv_wr_ready", 64'(wr_ready_o), 64'(tv[i].ready));
         chk("tv_tiles", 64'(tiles_avail_o), 64'(tv[i].tiles));
         chk("tv_rd_data", rd_data_o, tv[i].data);
      end

      do_reset();
      for (int k = 1; k <= 32; k++) step(1'b1, row(k), 1'b0);
      chk("full_ready", 64'(wr_ready_o), 64'd0);
      chk("full_tiles", 64'(tiles_avail_o), 64'd4);
      step(1'b1, row(99), 1'b0);
      chk("stall_ready", 64'(wr_ready_o), 64'd0);
      step(1'b0, 64'd0, 1'b1);
      chk("pop_ready", 64'(wr_ready_o), 64'd1);
      chk("pop_data", rd_data_o, row(1));

      for (int k = 0; k < 2; k++) step(1'b0, 64'd0, 1'b1);
      for (int k = 0; k < 5; k++) step(1'b0, 64'd0, 1'b0);
      for (int k = 4; k <= 8; k++) begin
         step(1'b0, 64'd0, 1'b1);
         chk("resume_data", rd_data_o, row(k));
         chk("resume_last", 64'(rd_last_o), 64'(k == 8));
      end
      chk("resume_tiles", 64'(tiles_avail_o), 64'd3);

      do_reset();
      for (int k = 0; k < 8; k++) step(1'b1, {$urandom, $urandom}, 1'b0);
      for (int k = 0; k < 100; k++) begin
         step(1'b1, {$urandom, $urandom}, 1'b1);
         chk("steady_tiles", 64'(tiles_avail_o), 64'd1);
      end

      for (int k = 0; k < 400; k++)
         step($urandom_range(0, 9) < 6, {$urandom, $urandom}, $urandom_range(0, 1) == 1);

      do_reset();
      for (int k = 1; k <= 19; k++) step(1'b1, row(k), 1'b0);
      step(1'b0, 64'd0, 1'b1);
      #2 rst_i = 1'b0;
      #1;
      chk("arst_ready", 64'(wr_ready_o), 64'd1);
      chk("arst_rd_valid", 64'(rd_valid_o), 64'd0);
      chk("arst_rd_last", 64'(rd_last_o), 64'd0);
      chk("arst_rd_data", rd_data_o, 64'd0);
      chk("arst_wf_valid", 64'(weight_fifo_valid_output), 64'd0);
      chk("arst_tiles", 64'(tiles_avail_o), 64'd0);
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b1;
      model_reset();
      for (int k = 0; k < 8; k++) step(1'b1, row(8'h40 + k), 1'b0);
      for (int k = 0; k < 8; k++) begin
         step(1'b0, 64'd0, 1'b1);
         chk("post_rst_data", rd_data_o, row(8'h40 + k));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
